// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates two byte sources onto a single uart_tx.
// Requester 0 sends single bytes, requester 1 sends indexed bursts. Each frame is
// started with a one-cycle tx_ctrl pulse, then followed into busy and back to idle.
// A fixed idle gap is inserted after every frame.
module uart_tx_sched #(
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [3:0] req1_len,
  output logic [3:0] req1_idx,
  input  logic [7:0] req1_byte,
  output logic       req1_ack,
  output logic       req1_done,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Terminal counts. For GAP_CYCLES=0 the GAP state is never entered, so the
  // wrapped value of GAP_LAST is never compared.
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [1:0]  r_grant, w_grant_next;
  logic        r_last_is_req1, w_last_next;
  logic [3:0]  r_len, w_len_next;
  logic [3:0]  r_idx, w_idx_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [7:0]  r_tx_byte, w_tx_byte_next;
  logic        r_tx_ctrl, w_tx_ctrl_next;
  logic        r_req0_ack, w_req0_ack_next;
  logic        r_req1_ack, w_req1_ack_next;
  logic        r_req1_done, w_req1_done_next;
  logic        r_err, w_err_next;
  logic        w_frame_end;
  logic        w_gap_exit;

  // Next-state and next-output logic. Pulses and tx_byte are registered, so a
  // LOAD decision becomes visible in the following cycle (request at N -> tx_ctrl at N+2).
  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_last_next      = r_last_is_req1;
    w_len_next       = r_len;
    w_idx_next       = r_idx;
    w_cnt_next       = r_cnt;
    w_tx_byte_next   = r_tx_byte;
    w_tx_ctrl_next   = 1'b0;
    w_req0_ack_next  = 1'b0;
    w_req1_ack_next  = 1'b0;
    w_req1_done_next = 1'b0;
    w_err_next       = r_err;
    w_frame_end      = 1'b0;
    w_gap_exit       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (tx_ready && (req0_valid || req1_valid)) begin
          w_state_next = S_LOAD;
          w_idx_next   = 4'd0;
          // Round robin: req1 wins only if alone or if req0 was granted last.
          if (req1_valid && (!req0_valid || !r_last_is_req1)) begin
            w_grant_next = 2'b10;
            w_last_next  = 1'b1;
            w_len_next   = req1_len;
          end else begin
            w_grant_next = 2'b01;
            w_last_next  = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (r_grant[1] && (r_len == 4'd0)) begin
          // Empty burst: nothing to send, just report completion.
          w_state_next     = S_IDLE;
          w_grant_next     = 2'b00;
          w_req1_done_next = 1'b1;
        end else begin
          w_tx_ctrl_next  = 1'b1;
          w_tx_byte_next  = r_grant[1] ? req1_byte : req0_byte;
          w_req0_ack_next = r_grant[0];
          w_req1_ack_next = r_grant[1];
          w_state_next    = S_WAIT_BUSY;
          w_cnt_next      = 16'd0;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_cnt == BUSY_LAST) begin
          // uart_tx never went busy: flag it and move on as if the frame was sent.
          w_err_next  = 1'b1;
          w_frame_end = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          w_frame_end = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_gap_exit = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_frame_end) begin
      if (GAP_CYCLES == 0) begin
        w_gap_exit = 1'b1;
      end else begin
        w_state_next = S_GAP;
        w_cnt_next   = 16'd0;
      end
    end

    // End of gap: continue the burst, or release the grant.
    if (w_gap_exit) begin
      if (r_grant[1] && (r_idx != (r_len - 4'd1))) begin
        w_state_next = S_LOAD;
        w_idx_next   = r_idx + 4'd1;
      end else begin
        w_state_next     = S_IDLE;
        w_grant_next     = 2'b00;
        w_idx_next       = 4'd0;
        w_req1_done_next = r_grant[1];
      end
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_grant        <= 2'b00;
      r_last_is_req1 <= 1'b1;
      r_len          <= 4'd0;
      r_idx          <= 4'd0;
      r_cnt          <= 16'd0;
      r_tx_byte      <= 8'd0;
      r_tx_ctrl      <= 1'b0;
      r_req0_ack     <= 1'b0;
      r_req1_ack     <= 1'b0;
      r_req1_done    <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_grant        <= w_grant_next;
      r_last_is_req1 <= w_last_next;
      r_len          <= w_len_next;
      r_idx          <= w_idx_next;
      r_cnt          <= w_cnt_next;
      r_tx_byte      <= w_tx_byte_next;
      r_tx_ctrl      <= w_tx_ctrl_next;
      r_req0_ack     <= w_req0_ack_next;
      r_req1_ack     <= w_req1_ack_next;
      r_req1_done    <= w_req1_done_next;
      r_err          <= w_err_next;
    end
  end

  assign req0_ack    = r_req0_ack;
  assign req1_ack    = r_req1_ack;
  assign req1_done   = r_req1_done;
  assign req1_idx    = r_idx;
  assign tx_ctrl     = r_tx_ctrl;
  assign tx_byte     = r_tx_byte;
  assign grant       = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple uart_tx ready model and
// counter-based requesters. All DUT outputs are observed on the falling edge.
module tb_uart_tx_sched;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_byte = 8'h00;
  logic [3:0] req1_len = 4'd0;
  logic [7:0] req1_byte;
  logic       tx_ready = 1'b1;
  logic       req0_ack, req1_ack, req1_done, tx_ctrl, busy, err_timeout;
  logic [3:0] req1_idx;
  logic [7:0] tx_byte;
  logic [1:0] grant;

  logic [7:0] r1_mem [16];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  // requester bookkeeping: stimulus posts, monitor counts completions
  int  r0_posted = 0, r1_posted = 0;
  logic hold = 1'b0;
  logic stuck = 1'b0;
  int  r0_ack_cnt = 0, r1_ack_cnt = 0, r1_done_cnt = 0, busy_cycles = 0;
  int  tx_cyc_q[$];
  logic [7:0] tx_byte_q[$];
  logic [1:0] tx_grant_q[$];
  logic [3:0] r1_idx_q[$];
  int  done_cyc_q[$];
  logic pend = 1'b0;
  int  mcnt = 0;

  assign req0_valid = hold | (r0_posted != r0_ack_cnt);
  assign req1_valid = hold | (r1_posted != r1_done_cnt);
  assign req1_byte  = r1_mem[req1_idx];

  uart_tx_sched #(.GAP_CYCLES(2), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_byte(req0_byte), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_len(req1_len), .req1_idx(req1_idx),
    .req1_byte(req1_byte), .req1_ack(req1_ack), .req1_done(req1_done),
    .tx_ctrl(tx_ctrl), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: goes busy the cycle after tx_ctrl, stays busy FRAME cycles
  always @(negedge clk) begin
    if (rst) begin
      tx_ready <= 1'b1;
      pend     <= 1'b0;
      mcnt     <= 0;
    end else begin
      pend <= tx_ctrl && !stuck;
      if (pend) begin
        tx_ready <= 1'b0;
        mcnt     <= FRAME - 1;
      end else if (!tx_ready) begin
        if (mcnt == 0) tx_ready <= 1'b1;
        else mcnt <= mcnt - 1;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (busy) busy_cycles <= busy_cycles + 1;
    if (req0_ack) r0_ack_cnt <= r0_ack_cnt + 1;
    if (req1_ack) begin
      r1_ack_cnt <= r1_ack_cnt + 1;
      r1_idx_q.push_back(req1_idx);
    end
    if (req1_done) begin
      r1_done_cnt <= r1_done_cnt + 1;
      done_cyc_q.push_back(cyc);
    end
    if (tx_ctrl) begin
      tx_cyc_q.push_back(cyc);
      tx_byte_q.push_back(tx_byte);
      tx_grant_q.push_back(grant);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k = 0;
    while (tx_byte_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, tx_byte_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((busy || req0_valid || req1_valid || !tx_ready) && k < budget) begin
      tick();
      k++;
    end
    check(tag, {busy, req0_valid, req1_valid}, 3'b000);
  endtask

  initial begin
    int c, base, b0, d0, a0, t;
    for (int i = 0; i < 16; i++) r1_mem[i] = 8'h00;

    // reset values
    tick(); tick(); tick();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {tx_ctrl, req0_ack, req1_ack, req1_done}, 4'b0000);
    check("rst_txbyte", tx_byte, 8'h00);
    check("rst_idx", req1_idx, 4'd0);
    check("rst_err", err_timeout, 1'b0);
    rst = 1'b0;
    tick();

    // single req0 byte
    c = cyc; b0 = busy_cycles; base = tx_byte_q.size();
    req0_byte = 8'h9D; r0_posted++;
    wait_tx("t1_tx", base + 1, 30);
    wait_idle("t1_idle", 60);
    check("t1_latency", tx_cyc_q[base], c + 2);
    check("t1_byte", tx_byte_q[base], 8'h9D);
    check("t1_grant", tx_grant_q[base], 2'b01);
    check("t1_acks", r0_ack_cnt, 1);
    check("t1_busy_cycles", busy_cycles - b0, 15);
    check("t1_ntx", tx_byte_q.size(), base + 1);
    $display("txn t1: req0 byte 9D sent");

    // req1 burst of 3 with req0 waiting
    base = tx_byte_q.size(); d0 = r1_done_cnt;
    r1_mem[0] = 8'h48; r1_mem[1] = 8'h41; r1_mem[2] = 8'h4E;
    req1_len = 4'd3; r1_posted++;
    req0_byte = 8'h55; r0_posted++;
    wait_tx("t2_tx", base + 4, 300);
    wait_idle("t2_idle", 100);
    check("t2_b0", tx_byte_q[base], 8'h48);
    check("t2_b1", tx_byte_q[base + 1], 8'h41);
    check("t2_b2", tx_byte_q[base + 2], 8'h4E);
    check("t2_b3", tx_byte_q[base + 3], 8'h55);
    check("t2_g012", {tx_grant_q[base], tx_grant_q[base + 1], tx_grant_q[base + 2]}, 6'b101010);
    check("t2_g3", tx_grant_q[base + 3], 2'b01);
    check("t2_idx", {r1_idx_q[0], r1_idx_q[1], r1_idx_q[2]}, 12'h012);
    check("t2_done", r1_done_cnt - d0, 1);
    check("t2_req0_after_done", tx_cyc_q[base + 3] > done_cyc_q[done_cyc_q.size() - 1], 1);
    $display("txn t2: req1 burst 48 41 4E then req0 55");

    // alternation after reset with both always valid
    rst = 1'b1; tick(); rst = 1'b0;
    base = tx_byte_q.size();
    r1_mem[0] = 8'hB1; req1_len = 4'd1; req0_byte = 8'hA0;
    hold = 1'b1;
    wait_tx("t3_tx", base + 3, 300);
    hold = 1'b0;
    r0_posted = r0_ack_cnt; r1_posted = r1_done_cnt;
    wait_idle("t3_idle", 100);
    check("t3_grants", {tx_grant_q[base], tx_grant_q[base + 1], tx_grant_q[base + 2]}, 6'b011001);
    check("t3_bytes", {tx_byte_q[base], tx_byte_q[base + 1], tx_byte_q[base + 2]}, 24'hA0B1A0);
    $display("txn t3: alternating grants");

    // busy timeout
    stuck = 1'b1; base = tx_byte_q.size();
    req0_byte = 8'h3C; r0_posted++;
    wait_tx("t4_tx", base + 1, 30);
    t = tx_cyc_q[base];
    tick_until(t + 3);
    check("t4_err_early", err_timeout, 1'b0);
    tick_until(t + 4);
    check("t4_err_set", err_timeout, 1'b1);
    tick_until(t + 6);
    check("t4_idle", busy, 1'b0);
    stuck = 1'b0; base = tx_byte_q.size();
    req0_byte = 8'h3D; r0_posted++;
    wait_tx("t4_tx2", base + 1, 30);
    wait_idle("t4_idle2", 60);
    check("t4_byte2", tx_byte_q[base], 8'h3D);
    check("t4_err_sticky", err_timeout, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t4_err_clr", err_timeout, 1'b0);
    tick();
    $display("txn t4: timeout flagged and cleared by reset");

    // zero-length burst
    base = tx_byte_q.size(); a0 = r1_ack_cnt; d0 = r1_done_cnt;
    req1_len = 4'd0; r1_posted++; c = cyc;
    tick();
    check("t5_grant", grant, 2'b10);
    tick();
    check("t5_done", req1_done, 1'b1);
    tick();
    check("t5_done_pulse", req1_done, 1'b0);
    check("t5_no_tx", tx_byte_q.size(), base);
    check("t5_no_ack", r1_ack_cnt, a0);
    check("t5_done_cnt", r1_done_cnt, d0 + 1);
    req0_byte = 8'hE1; r0_posted++; r1_posted++;
    tick();
    check("t5_rr_after_len0", grant, 2'b01);
    wait_idle("t5_idle", 100);
    $display("txn t5: zero-length burst");

    // reset in the middle of a burst
    a0 = r1_ack_cnt; d0 = r1_done_cnt;
    r1_mem[0] = 8'h11; r1_mem[1] = 8'h22; r1_mem[2] = 8'h33;
    req1_len = 4'd3; r1_posted++;
    c = 0;
    while (r1_ack_cnt < a0 + 2 && c < 200) begin tick(); c++; end
    check("t6_two_acks", r1_ack_cnt, a0 + 2);
    rst = 1'b1; tick();
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_pulses", {tx_ctrl, req0_ack, req1_ack, req1_done}, 4'b0000);
    check("t6_rst_idx", req1_idx, 4'd0);
    check("t6_rst_txbyte", tx_byte, 8'h00);
    rst = 1'b0; r1_posted = r1_done_cnt;
    for (int i = 0; i < 30; i++) tick();
    check("t6_no_done", r1_done_cnt, d0);
    check("t6_no_more_acks", r1_ack_cnt, a0 + 2);
    base = tx_byte_q.size();
    req0_byte = 8'h77; r0_posted++;
    wait_tx("t6_tx", base + 1, 30);
    wait_idle("t6_idle", 60);
    check("t6_byte", tx_byte_q[base], 8'h77);
    check("t6_grant", tx_grant_q[base], 2'b01);
    $display("txn t6: reset mid-burst then req0 77");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles inserted after each completed frame before the next tx_ctrl.
REQ-002 Parameter BUSY_TIMEOUT, default 4: cycles allowed for tx_ready to fall after a tx_ctrl pulse.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 (keypad guess) has one byte pending.
REQ-006 req0_byte  input  8  requester 0 data, stable while req0_valid.
REQ-007 req0_ack  output  1  one-cycle pulse: req0_byte latched.
REQ-008 req1_valid  input  1  requester 1 (game-status message) has a burst pending.
REQ-009 req1_len  input  4  burst length in bytes, 0..15, sampled at grant.
REQ-010 req1_idx  output  4  index of the byte requester 1 must present on req1_byte in the same cycle.
REQ-011 req1_byte  input  8  requester 1 data for req1_idx.
REQ-012 req1_ack  output  1  one-cycle pulse per req1 byte latched.
REQ-013 req1_done  output  1  one-cycle pulse: burst finished.
REQ-014 tx_ctrl  output  1  one-cycle start pulse to uart_tx.
REQ-015 tx_byte  output  8  byte to uart_tx, held from tx_ctrl until frame completes.
REQ-016 tx_ready  input  1  uart_tx transmit_ready; high = idle.
REQ-017 grant  output  2  one-hot current owner ({req1,req0}); 0 when idle.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 err_timeout  output  1  sticky: tx_ready never fell within BUSY_TIMEOUT.

Function
REQ-020 States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
REQ-021 IDLE: start only when tx_ready=1 and a request is valid; winner takes grant next cycle, state -> LOAD.
REQ-022 Arbitration round-robin on last_grant: both valid -> grant the one not last granted; single valid -> that one.
REQ-023 Burst not preemptible: req1 keeps grant for all req1_len bytes regardless of req0.
REQ-024 LOAD: latch byte into tx_byte, pulse tx_ctrl and the owner's ack in the same cycle; -> WAIT_BUSY.
REQ-025 WAIT_BUSY: on tx_ready=0 -> WAIT_DONE; counter reaching BUSY_TIMEOUT -> set err_timeout, treat frame as sent, -> GAP.
REQ-026 WAIT_DONE: on tx_ready=1 -> GAP; no timeout in this state.
REQ-027 GAP: count GAP_CYCLES cycles; then req1 with bytes remaining -> LOAD with req1_idx+1, else -> IDLE.
REQ-028 Latency: request valid in IDLE at cycle N -> tx_ctrl at cycle N+2.
REQ-029 Frame completion of last req1 byte: req1_done pulses on the GAP->IDLE transition cycle.
REQ-030 req1_len=0 at grant: no tx_ctrl, no req1_ack; req1_done pulses next cycle; -> IDLE; last_grant updated.
REQ-031 req1_idx starts at 0 on grant, increments by 1 per byte, never exceeds req1_len-1; 0 when not granted.
REQ-032 tx_ctrl never asserted twice without an intervening tx_ready low or timeout.
REQ-033 Requester deasserting valid after grant is ignored; granted transaction completes.
REQ-034 GAP_CYCLES=0: GAP lasts zero cycles (direct transition).

Reset
REQ-035 rst=1 at a rising edge: state IDLE, last_grant=req1 (req0 wins first tie), counters 0.
REQ-036 Reset values: tx_ctrl, tx_byte, req0_ack, req1_ack, req1_done, req1_idx, grant, busy, err_timeout all 0.
REQ-037 Reset mid-burst aborts: no further ack/done, tx_ctrl low from the cycle after rst sampled.

Verification
REQ-038 Single req0 byte 8'h9D, tx_ready model 1->0 after 1 cycle, frame 10 cycles -> one tx_ctrl at N+2, tx_byte=8'h9D, one req0_ack, busy high until GAP ends.
REQ-039 req1 len=3 bytes {8'h48,8'h41,8'h4E} with req0 asserted throughout -> three frames in order, idx 0,1,2, one req1_done, req0 served only after done.
REQ-040 Both valid after reset, repeated -> grants alternate req0, req1, req0; never same requester twice when other waiting.
REQ-041 tx_ready held high after tx_ctrl -> err_timeout=1 after BUSY_TIMEOUT cycles, sequencer returns to IDLE, flag stays until rst.
REQ-042 req1_len=0 -> zero tx_ctrl, req1_done one cycle after grant.
REQ-043 rst during 2nd byte of 3-byte burst -> all outputs 0 next cycle, no req1_done, new req0 afterwards served normally.
